// File: rtl/gate_vector_decoder_pkg.sv
// Shared types and constants for the gate-vector decoder: FSM state encoding
// and the four legal 7-gate words {xnor, xor, nor, nand, or, and, not a}.
package gate_vector_decoder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   localparam logic [6:0] W_00 = 7'h59;
   localparam logic [6:0] W_01 = 7'h2D;
   localparam logic [6:0] W_10 = 7'h2C;
   localparam logic [6:0] W_11 = 7'h46;

   localparam int GAP_W = 8;

endpackage

// File: rtl/gate_vector_decoder_if.sv
// Serial bit input and decoded-result output of the gate-vector decoder.
// Both channels use valid/ready: a transfer happens on a rising clock edge when
// valid and ready are both 1; the source holds data and valid until that edge.
interface gate_vector_decoder_if;

   logic in_bit;
   logic in_valid;
   logic in_ready;
   logic out_valid;
   logic out_ready;
   logic out_a;
   logic out_b;
   logic out_err;

   modport master (
      output in_bit, in_valid, out_ready,
      input  in_ready, out_valid, out_a, out_b, out_err
   );

   modport slave (
      input  in_bit, in_valid, out_ready,
      output in_ready, out_valid, out_a, out_b, out_err
   );

endinterface

// File: rtl/gate_vector_check.sv
// Combinational inverse of the 7-gate vector: legal word -> (a,b), else err
// with a=b=0.
module gate_vector_check
   import gate_vector_decoder_pkg::*;
(
   input  logic [6:0] word,
   output logic       a,
   output logic       b,
   output logic       err
);

   always_comb begin
      a   = 1'b0;
      b   = 1'b0;
      err = 1'b0;
      case (word)
         W_00: begin
            a = 1'b0;
            b = 1'b0;
         end
         W_01: b = 1'b1;
         W_10: a = 1'b1;
         W_11: begin
            a = 1'b1;
            b = 1'b1;
         end
         default: err = 1'b1;
      endcase
   end

endmodule

// File: rtl/gate_vector_decoder.sv
// Deserializes 7-bit gate vectors (y[0] first), decodes them to (a,b) and
// holds the registered result until the consumer takes it.
module gate_vector_decoder
   import gate_vector_decoder_pkg::*;
#(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 8
)
(
   input  logic                 clk,
   input  logic                 rst_n,
   gate_vector_decoder_if.slave bus,
   output logic [CNT_W-1:0]     err_count,
   output state_t               fsm_state
);

   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT - 1);

   state_t           state;
   state_t           state_nx;
   logic [5:0]       shift_q;
   logic [2:0]       bit_idx;
   logic [GAP_W-1:0] gap_cnt;
   logic             accept;
   logic             load;
   logic             abort_frame;
   logic             err_inc;
   logic [6:0]       word;
   logic             chk_a;
   logic             chk_b;
   logic             chk_err;

   // Bit 6 is decoded straight off the input so the result registers on its edge.
   assign word      = {bus.in_bit, shift_q};
   assign fsm_state = state;

   gate_vector_check u_check (
      .word (word),
      .a    (chk_a),
      .b    (chk_b),
      .err  (chk_err)
   );

   always_comb begin
      state_nx      = state;
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      accept        = 1'b0;
      load          = 1'b0;
      abort_frame   = 1'b0;
      case (state)
         ST_IDLE: begin
            bus.in_ready = 1'b1;
            accept       = bus.in_valid;
            if (accept) state_nx = ST_SHIFT;
         end
         ST_SHIFT: begin
            bus.in_ready = 1'b1;
            accept       = bus.in_valid;
            if (accept && bit_idx == 3'd6) begin
               load     = 1'b1;
               state_nx = ST_HOLD;
            end else if (!accept && gap_cnt == GAP_LAST) begin
               abort_frame = 1'b1;
               state_nx    = ST_IDLE;
            end
         end
         ST_HOLD: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // Illegal word and timeout are mutually exclusive, but OR them so a single
   // cycle can only ever add one.
   assign err_inc = (load && chk_err) || abort_frame;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         shift_q     <= '0;
         bit_idx     <= '0;
         gap_cnt     <= '0;
         bus.out_a   <= 1'b0;
         bus.out_b   <= 1'b0;
         bus.out_err <= 1'b0;
         err_count   <= '0;
      end else begin
         state <= state_nx;
         if (load) begin
            shift_q     <= '0;
            bit_idx     <= '0;
            gap_cnt     <= '0;
            bus.out_a   <= chk_a;
            bus.out_b   <= chk_b;
            bus.out_err <= chk_err;
         end else if (accept) begin
            shift_q <= {bus.in_bit, shift_q[5:1]};
            bit_idx <= bit_idx + 3'd1;
            gap_cnt <= '0;
         end else if (abort_frame) begin
            shift_q <= '0;
            bit_idx <= '0;
            gap_cnt <= '0;
         end else if (state == ST_SHIFT) begin
            gap_cnt <= gap_cnt + GAP_W'(1);
         end
         if (err_inc && err_count != {CNT_W{1'b1}}) begin
            err_count <= err_count + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_gate_vector_decoder.sv
// Directed bench for gate_vector_decoder: hand-computed words and results,
// expected results queued and checked at each output handshake.
module tb_gate_vector_decoder;
   import gate_vector_decoder_pkg::*;

   localparam int TIMEOUT = 15;
   localparam int CNT_W   = 8;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic [CNT_W-1:0] err_count;
   state_t           fsm_state;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_err  = 0;
   logic [2:0] exp_q[$];
   logic [2:0] mon_exp;

   gate_vector_decoder_if bus ();

   gate_vector_decoder #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .err_count (err_count),
      .fsm_state (fsm_state)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic bump_err();
      if (exp_err < 255) exp_err++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_bit(input logic b);
      int waited;
      waited = 0;
      bus.in_bit   = b;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (waited >= 50) check_eq("in_ready_wait", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [6:0] w, input logic [2:0] res);
      exp_q.push_back(res);
      if (res[2]) bump_err();
      for (int i = 0; i < 7; i++) send_bit(w[i]);
   endtask

   task automatic check_result(input string tag, input logic [2:0] res);
      check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, "_err_a_b"}, 32'({bus.out_err, bus.out_a, bus.out_b}), 32'(res));
      check_eq({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
   endtask

   // ---------------- scoreboard monitor ----------------
   always begin
      @(negedge clk);
      #1;
      if (rst_n) begin
         if (exp_q.size() == 0) begin
            check_eq("no_spurious_valid", 32'(bus.out_valid), 32'd0);
         end else if (bus.out_valid && bus.out_ready) begin
            mon_exp = exp_q.pop_front();
            check_eq("handshake_result", 32'({bus.out_err, bus.out_a, bus.out_b}), 32'(mon_exp));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [6:0] w;
      bus.in_bit    = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;

      // reset values
      repeat (3) @(negedge clk);
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_out_err_a_b", 32'({bus.out_err, bus.out_a, bus.out_b}), 32'd0);
      check_eq("rst_err_count", 32'(err_count), 32'd0);
      check_eq("rst_state", 32'(fsm_state), 32'(ST_IDLE));
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("ready_after_reset", 32'(bus.in_ready), 32'd1);

      // single word 7'h59, latency check on the last bit
      w = 7'h59;
      exp_q.push_back(3'b000);
      for (int i = 0; i < 6; i++) send_bit(w[i]);
      check_eq("valid_before_bit6", 32'(bus.out_valid), 32'd0);
      send_bit(w[6]);
      check_result("w59", 3'b000);

      // four legal words back to back
      send_word(7'h59, 3'b000);
      check_result("seq_00", 3'b000);
      send_word(7'h2D, 3'b001);
      check_result("seq_01", 3'b001);
      send_word(7'h2C, 3'b010);
      check_result("seq_10", 3'b010);
      send_word(7'h46, 3'b011);
      check_result("seq_11", 3'b011);

      // illegal word
      send_word(7'h7F, 3'b100);
      check_result("illegal_7f", 3'b100);
      check_eq("err_count_one", 32'(err_count), 32'd1);

      // timeout after 3 bits
      @(negedge clk);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      repeat (TIMEOUT - 1) @(negedge clk);
      check_eq("gap_still_shift", 32'(fsm_state), 32'(ST_SHIFT));
      @(negedge clk);
      bump_err();
      check_eq("timeout_idle", 32'(fsm_state), 32'(ST_IDLE));
      check_eq("timeout_err_count", 32'(err_count), 32'(exp_err));
      check_eq("timeout_err_count_two", 32'(err_count), 32'd2);
      send_word(7'h46, 3'b011);
      check_result("after_timeout", 3'b011);

      // backpressure in HOLD with in_valid high
      @(negedge clk);
      bus.out_ready = 1'b0;
      send_word(7'h2D, 3'b001);
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check_eq("hold_in_ready", 32'(bus.in_ready), 32'd0);
         check_eq("hold_state", 32'(fsm_state), 32'(ST_HOLD));
         check_result("hold_stable", 3'b001);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check_eq("release_idle", 32'(fsm_state), 32'(ST_IDLE));
      check_eq("release_ready", 32'(bus.in_ready), 32'd1);
      send_word(7'h2C, 3'b010);
      check_result("after_release", 3'b010);

      // reset after 4 bits
      @(negedge clk);
      w = 7'h59;
      for (int i = 0; i < 4; i++) send_bit(w[i]);
      rst_n = 1'b0;
      #1;
      exp_err = 0;
      check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("midrst_err_a_b", 32'({bus.out_err, bus.out_a, bus.out_b}), 32'd0);
      check_eq("midrst_err_count", 32'(err_count), 32'd0);
      check_eq("midrst_state", 32'(fsm_state), 32'(ST_IDLE));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      check_eq("post_rst_idle", 32'(fsm_state), 32'(ST_IDLE));
      send_word(7'h59, 3'b000);
      check_result("post_rst_word", 3'b000);

      // saturation of err_count
      for (int k = 0; k < 256; k++) send_word(7'h00, 3'b100);
      @(negedge clk);
      check_eq("sat_err_count", 32'(err_count), 32'd255);
      send_bit(1'b0);
      repeat (TIMEOUT) @(negedge clk);
      check_eq("sat_timeout_idle", 32'(fsm_state), 32'(ST_IDLE));
      check_eq("sat_after_timeout", 32'(err_count), 32'd255);

      repeat (3) @(negedge clk);
      check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gate_vector_decoder.md
GATE_VECTOR_DECODER -- requirements
Module: gate_vector_decoder

Interface
REQ-001 Parameter: TIMEOUT, 15, max idle cycles between accepted bits inside a frame (range 1..255).
REQ-002 Parameter: CNT_W, 8, width of err_count.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 Port: in_bit  input  1  serial gate-vector bit, y[0] first, y[6] last.
REQ-006 Port: in_valid  input  1  in_bit is valid this cycle.
REQ-007 Port: in_ready  output  1  decoder accepts a bit this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-008 Port: out_valid  output  1  decoded result available.
REQ-009 Port: out_ready  input  1  consumer accepts the result.
REQ-010 Port: out_a  output  1  recovered operand a.
REQ-011 Port: out_b  output  1  recovered operand b.
REQ-012 Port: out_err  output  1  received word is not a legal gate vector.
REQ-013 Port: err_count  output  CNT_W  saturating count of illegal words plus timeouts.

Function
REQ-014 The word y[6:0] is the 7-gate vector {xnor, xor, nor, nand, or, and, not a}, and the block shall invert it back to (a,b).
REQ-015 Legal words: 7'h59 -> a=0,b=0; 7'h2D -> a=0,b=1; 7'h2C -> a=1,b=0; 7'h46 -> a=1,b=1.
REQ-016 Any other word: out_err=1, out_a=0, out_b=0; err_count increments.
REQ-017 FSM states: IDLE, SHIFT, HOLD.
REQ-018 IDLE: in_ready=1, out_valid=0; the first accepted bit loads position 0 and moves to SHIFT.
REQ-019 SHIFT: in_ready=1; each accepted bit fills the next position; acceptance of bit 6 moves to HOLD.
REQ-020 Latency: out_valid=1 in the cycle after bit 6 is accepted, with outputs registered.
REQ-021 HOLD: in_ready=0, out_valid=1, and out_a/out_b/out_err stay stable until out_ready=1.
REQ-022 HOLD with out_ready=1: go to IDLE next cycle; no same-cycle bypass, so the next bit can be accepted one cycle after the handshake.
REQ-023 SHIFT idle gap: a counter clears on each accepted bit; if it reaches TIMEOUT with no bit accepted, abort the frame, discard partial bits, increment err_count, return to IDLE, and produce no out_valid.
REQ-024 err_count saturates at all-ones and never wraps.
REQ-025 If an illegal word and a timeout would both count in the same cycle (impossible by construction), the count increments only once.
REQ-026 in_valid with in_ready=0 is ignored; the upstream holds the bit.

Reset
REQ-027 rst_n=0 asynchronously forces: state=IDLE, shift register=0, bit index=0, gap counter=0, out_valid=0, out_a=0, out_b=0, out_err=0, err_count=0.
REQ-028 in_ready=1 in the first cycle after rst_n deasserts.
REQ-029 Reset mid-frame or in HOLD discards all data; no result is emitted afterward.

Structure
REQ-030 A shared package holds the state enum and the four legal-word constants (W_00=7'h59, W_01=7'h2D, W_10=7'h2C, W_11=7'h46).
REQ-031 One sub-module, gate_vector_check, is combinational: 7-bit word in; a, b, err out.
REQ-032 The FSM, deserializer, gap counter and error counter live in gate_vector_decoder.

Verification
REQ-033 Send 1,0,0,1,1,0,1 (word 7'h59) back-to-back with out_ready=1 -> out_valid one cycle after the 7th bit, a=0, b=0, err=0, err_count=0.
REQ-034 Send all four legal words consecutively -> results (0,0),(0,1),(1,0),(1,1) in order, err_count stays 0.
REQ-035 Send word 7'h7F -> out_err=1, a=b=0, err_count=1.
REQ-036 Send 3 bits, then idle TIMEOUT cycles -> no out_valid, err_count+1, FSM in IDLE; the next full legal word decodes correctly.
REQ-037 Hold out_ready=0 for 10 cycles in HOLD while in_valid=1 -> in_ready=0 and outputs stable throughout; release -> IDLE, then accept.
REQ-038 Assert rst_n=0 after 4 bits -> all outputs zero immediately; no spurious out_valid after release.
